// File: rtl/data_route_pkg.sv
// Shared types and constants for the data-route stream blocks.
// Optional build macro: STREAM_SERIALIZER_MSB_FIRST_EN (top slice first).
package data_route_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   localparam int DWIDTH_DEF = 32;

   // Counter width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stream_slice_mux.sv
// RATIO-way slice select of a wide word by beat index.
// STREAM_SERIALIZER_MSB_FIRST_EN reverses the beat-to-slice mapping.
module stream_slice_mux
   import data_route_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int RATIO  = 4,
   parameter int IW     = clog2_min1(RATIO)
) (
   input  logic [DWIDTH*RATIO-1:0] data,
   input  logic [IW-1:0]           idx,
   output logic [DWIDTH-1:0]       slice
);

   logic [IW-1:0] sel;

   always_comb begin
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
      sel = IW'(RATIO - 1) - idx;
`else
      sel = idx;
`endif
   end

   always_comb begin
      slice = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (sel == IW'(k)) slice = data[k*DWIDTH +: DWIDTH];
      end
   end

endmodule

// File: rtl/stream_serializer.sv
// Wide-to-narrow valid/ready downsizer: one word in, RATIO beats out.
// Build macro STREAM_SERIALIZER_MSB_FIRST_EN selects top-slice-first order.
module stream_serializer
   import data_route_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int RATIO  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DWIDTH*RATIO-1:0] s_in_tdata,
   input  logic                    s_in_tvalid,
   input  logic                    s_in_tlast,
   output logic                    s_in_tready,
   output logic [DWIDTH-1:0]       m_out_tdata,
   output logic                    m_out_tvalid,
   output logic                    m_out_tlast,
   input  logic                    m_out_tready
);

   localparam int IW = clog2_min1(RATIO);
   localparam logic [IW-1:0] IDX_LAST = IW'(RATIO - 1);

   state_t                    state, state_nx;
   logic [IW-1:0]             idx, idx_nx;
   logic [DWIDTH*RATIO-1:0]   hold_data;
   logic                      hold_last;
   logic                      last_beat;
   logic                      accept;

   assign last_beat = (idx == IDX_LAST);

   // Reloading on the final beat's handshake keeps the output bubble-free.
   assign s_in_tready = rst_n
                      & ((state == ST_IDLE) | (last_beat & m_out_tready));
   assign accept = s_in_tvalid & s_in_tready;

   assign m_out_tvalid = (state == ST_SEND);
   assign m_out_tlast  = (state == ST_SEND) & hold_last & last_beat;

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nx = ST_SEND;
               idx_nx   = '0;
            end
         end
         ST_SEND: begin
            if (m_out_tready) begin
               if (!last_beat) begin
                  idx_nx = idx + IW'(1);
               end else if (accept) begin
                  idx_nx = '0;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         hold_data <= '0;
         hold_last <= 1'b0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         if (accept) begin
            hold_data <= s_in_tdata;
            hold_last <= s_in_tlast;
         end
      end
   end

   // Data is muxed straight off the holding register so it holds in IDLE.
   stream_slice_mux #(
      .DWIDTH (DWIDTH),
      .RATIO  (RATIO),
      .IW     (IW)
   ) u_mux (
      .data  (hold_data),
      .idx   (idx),
      .slice (m_out_tdata)
   );

endmodule

// File: doc/stream_serializer.md
Name: stream_serializer

Overview:
- Valid/ready stream width downsizer for the data-route path: accepts one wide word of RATIO*DWIDTH bits and emits it as RATIO narrow beats of DWIDTH bits.
- Transmit-side counterpart of the lane packer feeding the systolic array.
- Sits between a wide buffer read port and a narrow register-slice chain.
- Sustains one narrow beat per cycle with no bubbles between consecutive wide words.

Parameters:
- DWIDTH, 32, width of one output beat in bits.
- RATIO, 4, number of output beats per input word; legal range 1..16.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- s_in_tdata  input  DWIDTH*RATIO  wide input word; slice k is bits [k*DWIDTH +: DWIDTH].
- s_in_tvalid  input  1  input word valid.
- s_in_tlast  input  1  input word is last of packet.
- s_in_tready  output  1  block can accept a word this cycle.
- m_out_tdata  output  DWIDTH  current narrow beat.
- m_out_tvalid  output  1  narrow beat valid.
- m_out_tlast  output  1  final beat of a word whose s_in_tlast was 1.
- m_out_tready  input  1  downstream accepts beat.

Behaviour:
- Clock is clk. Reset rst_n is synchronous and active-low.
- State machine: IDLE and SEND.
- Storage: holding register hold_data (DWIDTH*RATIO bits), hold_last, beat counter idx (clog2(RATIO) bits, minimum 1).
- Reset:
  - state=IDLE, idx=0, hold_data=0, hold_last=0.
  - m_out_tvalid=0, m_out_tlast=0.
  - s_in_tready is forced 0 while rst_n=0.
  - Reset mid-word discards the partial word; no further beats of it are emitted.
- last_beat = (idx==RATIO-1).
- s_in_tready = rst_n & ((state==IDLE) | (last_beat & m_out_tready)). Combinational from m_out_tready; this is the only combinational in-to-out path.
- Input accept (s_in_tvalid & s_in_tready):
  - Load hold_data and hold_last.
  - Set idx=0 and state=SEND.
- SEND:
  - m_out_tvalid=1.
  - m_out_tdata = slice idx of hold_data (MSB-first variant below).
  - m_out_tlast = hold_last & last_beat.
  - On m_out_tready with idx<RATIO-1: idx increments.
  - On m_out_tready with last_beat: if a new word is accepted the same cycle, reload and stay in SEND with idx=0 (zero bubble); otherwise go to IDLE.
- IDLE: m_out_tvalid=0, m_out_tdata holds last value, m_out_tlast=0.
- Latency: word accepted at edge N gives its first beat valid after edge N; beat k is valid no earlier than k cycles later.
- Throughput: one word per RATIO cycles with continuous m_out_tready=1.
- Back-pressure: with m_out_tready=0, m_out_tvalid, m_out_tdata, m_out_tlast and idx stay stable. No beat is dropped or duplicated.
- m_out_tvalid never deasserts without a handshake, except on reset.
- RATIO=1: idx is constant 0 and last_beat is always 1. The block behaves as a single-entry pipeline register with tready = IDLE | m_out_tready.
- s_in_tdata and s_in_tlast are ignored when not accepted.

Optional Feature:
- Macro: STREAM_SERIALIZER_MSB_FIRST_EN.
- Defined: beat k carries slice RATIO-1-k; the top slice is emitted first. Other timing is unchanged, and m_out_tlast still marks the final beat.
- Undefined: beat k carries slice k; the LSB slice is emitted first.

Decomposition:
- Shared package (data_route_pkg):
  - state encodings ST_IDLE=1'b0, ST_SEND=1'b1.
  - Function clog2_min1 for counter width.
  - Default DWIDTH constant shared with the register slice.
- One sub-module: stream_slice_mux, a combinational RATIO-way slice select with parameters DWIDTH and RATIO and input idx. The MSB-first mapping is applied there.
- State, counter and handshake logic stay in the top module.

Test Plan:
- RATIO=4, DWIDTH=8, m_out_tready=1: send word 0x44332211 with tlast=1. Required: beats 0x11, 0x22, 0x33, 0x44 on four consecutive cycles, m_out_tlast only on 0x44, s_in_tready high in the 0x44 cycle.
- Back-to-back: words 0xDDCCBBAA and 0x88776655, both tvalid continuous. Required: 8 consecutive valid beats AA, BB, CC, DD, 55, 66, 77, 88 with no gap; second word accepted in the same cycle DD leaves.
- Back-pressure: drop m_out_tready for 3 cycles while beat 0x22 is presented. Required: 0x22 held stable with valid=1, idx unchanged, s_in_tready=0, and resume with 0x33 after release.
- Random tvalid/tready (10k words), compared against a reference queue. Required: exact beat order, tlast count equals packet count, no loss or duplication.
- Reset asserted after beat 0x22 of 0x44332211. Required: the next cycle has m_out_tvalid=0 and s_in_tready=0. After release, a new word 0x0000_00FF yields 0xFF, 0x00, 0x00, 0x00 only.
- MSB_FIRST_EN defined, RATIO=1 and RATIO=4 builds. Required: 0x44332211 emits 0x44, 0x33, 0x22, 0x11 with tlast on 0x11. The RATIO=1 build passes the word through with 1-cycle latency and full throughput.
